tlc_phase_scheduler: RTL

- Multi-approach phase scheduler for an intersection of up to N_APPR roads.
- Sensor requests and an emergency preempt select which single approach receives green. Selection is round-robin.
- Enforces minimum green, maximum green, yellow and all-red clearance timing.
- Drives per-approach light codes using the codebase encoding: Green=0, Yellow=1, Red=2.
- All timing advances on a one-cycle `tick` strobe from the shared timebase, so durations are in ticks, not clocks.

---
 rtl/tlc_phase_scheduler.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/tlc_phase_scheduler.sv
// Round-robin traffic-light phase scheduler: one approach at a time gets green.
// Min/max green, yellow and all-red clearance are counted in timebase ticks.
module tlc_phase_scheduler #(
  parameter int N_APPR    = 4,
  parameter int AW        = $clog2(N_APPR),
  parameter int CW        = 6,
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 29,
  parameter int YELLOW_T  = 5,
  parameter int ALLRED_T  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic [N_APPR-1:0]     req,
  input  logic                  preempt,
  input  logic [AW-1:0]         preempt_id,
  output logic [2*N_APPR-1:0]   lights,
  output logic [AW-1:0]         active,
  output logic                  served,
  output logic [2:0]            phase,
  output logic [CW-1:0]         timer
);

  localparam logic [2:0] S_CLEAR  = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_GREEN  = 3'd2;
  localparam logic [2:0] S_YELLOW = 3'd3;

  localparam logic [1:0] L_GREEN  = 2'd0;
  localparam logic [1:0] L_YELLOW = 2'd1;
  localparam logic [1:0] L_RED    = 2'd2;

  logic [2:0]    r_state;
  logic [2:0]    w_state_next;
  logic [CW-1:0] r_timer;
  logic [AW-1:0] r_active;
  logic [AW-1:0] r_last_grant;
  logic          r_served;

  logic [CW:0]   w_nt;
  logic          w_other_req;
  logic          w_ext;
  logic          w_hi_found;
  logic [AW-1:0] w_hi_pick;
  logic          w_any_found;
  logic [AW-1:0] w_any_pick;
  logic [AW-1:0] w_pick;

  assign w_nt = (CW+1)'(r_timer) + (CW+1)'(1);

  // Split requests into the green owner's own extension and everyone else.
  always_comb begin
    w_other_req = 1'b0;
    w_ext       = 1'b0;
    for (int i = 0; i < N_APPR; i++) begin
      if (AW'(i) == r_active) begin
        w_ext = req[i];
      end else if (req[i]) begin
        w_other_req = 1'b1;
      end
    end
  end

  // Round robin: lowest request above last_grant wins, else lowest overall.
  always_comb begin
    w_hi_found  = 1'b0;
    w_hi_pick   = '0;
    w_any_found = 1'b0;
    w_any_pick  = '0;
    for (int i = N_APPR - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_any_found = 1'b1;
        w_any_pick  = AW'(i);
        if (AW'(i) > r_last_grant) begin
          w_hi_found = 1'b1;
          w_hi_pick  = AW'(i);
        end
      end
    end
  end

  always_comb begin
    if (preempt) begin
      w_pick = preempt_id;
    end else if (w_hi_found) begin
      w_pick = w_hi_pick;
    end else if (w_any_found) begin
      w_pick = w_any_pick;
    end else begin
      w_pick = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_CLEAR;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_CLEAR: begin
        if (tick && w_nt == (CW+1)'(ALLRED_T)) begin
          w_state_next = S_SELECT;
        end
      end
      S_SELECT: begin
        w_state_next = S_GREEN;
      end
      S_GREEN: begin
        // A preempt for the current owner pins green; any other target forces yellow at once.
        if (preempt) begin
          if (preempt_id != r_active) begin
            w_state_next = S_YELLOW;
          end
        end else if (tick && w_other_req &&
                     ((w_nt >= (CW+1)'(MIN_GREEN) && !w_ext) ||
                      w_nt >= (CW+1)'(MAX_GREEN))) begin
          w_state_next = S_YELLOW;
        end
      end
      S_YELLOW: begin
        if (tick && w_nt == (CW+1)'(YELLOW_T)) begin
          w_state_next = S_CLEAR;
        end
      end
      default: begin
        w_state_next = S_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer      <= '0;
      r_active     <= '0;
      r_last_grant <= AW'(N_APPR - 1);
      r_served     <= 1'b0;
    end else begin
      r_served <= (r_state == S_GREEN) && (w_state_next == S_YELLOW);
      if (w_state_next != r_state) begin
        r_timer <= '0;
      end else if (tick) begin
        // Resting green stops counting at MAX_GREEN; elsewhere saturate at all-ones.
        if (r_state == S_GREEN && r_timer >= CW'(MAX_GREEN)) begin
          r_timer <= r_timer;
        end else if (r_timer != '1) begin
          r_timer <= r_timer + CW'(1);
        end
      end
      if (r_state == S_SELECT) begin
        r_active     <= w_pick;
        r_last_grant <= w_pick;
      end
    end
  end

  always_comb begin
    phase  = r_state;
    active = r_active;
    timer  = r_timer;
    served = r_served;
  end

  generate
    for (genvar gi = 0; gi < N_APPR; gi++) begin : g_light
      assign lights[2*gi+1:2*gi] =
        (r_state == S_GREEN  && r_active == AW'(gi)) ? L_GREEN  :
        (r_state == S_YELLOW && r_active == AW'(gi)) ? L_YELLOW : L_RED;
    end
  endgenerate

endmodule
